// File: rtl/serial_bit_alu.sv
// serial_bit_alu: bit-serial ALU, one bit-slice per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_bit_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic carry_q, carry_d, zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [3:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_shift, res_fin;
   logic bneg, bi, s, cn, sel, last, ovf, set;
   assign bneg = (ctrl_q == OP_SUB) | (ctrl_q == OP_SLT) | (ctrl_q == OP_SLTU);
   assign bi = b_q[0] ^ bneg;
   assign s = a_q[0] ^ bi ^ carry_q;
   assign cn = (a_q[0] & bi) | (a_q[0] & carry_q) | (bi & carry_q);
   assign ovf = carry_q ^ cn;
   assign set = s ^ ovf;
   assign last = cnt_q == CW'(WIDTH - 1);
   assign sel = (ctrl_q == OP_AND) ? a_q[0] & b_q[0] :
                (ctrl_q == OP_OR)  ? a_q[0] | b_q[0] :
                (ctrl_q == OP_XOR) ? a_q[0] ^ b_q[0] :
                (ctrl_q == OP_ADD || ctrl_q == OP_SUB) ? s : 1'b0;
   // Result bits shift in from the top so bit 0 lands in place after WIDTH steps.
   assign res_shift = {sel, res_q[WIDTH-1:1]};
   assign res_fin = (ctrl_q == OP_SLT)  ? {{(WIDTH-1){1'b0}}, set} :
                    (ctrl_q == OP_SLTU) ? {{(WIDTH-1){1'b0}}, ~cn} : res_shift;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      carry_d = carry_q;
      ctrl_d = ctrl_q;
      a_d = a_q;
      b_d = b_q;
      res_d = res_q;
      zero_d = zero_q;
      cout_d = cout_q;
      ovf_d = ovf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d = a;
            b_d = b;
            ctrl_d = ctrl;
            cnt_d = '0;
            carry_d = (ctrl == OP_SUB) | (ctrl == OP_SLT) | (ctrl == OP_SLTU);
            state_d = RUN;
         end
         RUN: begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            carry_d = cn;
            cnt_d = cnt_q + 1'b1;
            res_d = last ? res_fin : res_shift;
            if (last) begin
               zero_d = res_fin == '0;
               cout_d = cn & (ctrl_q == OP_ADD || bneg);
               ovf_d = ovf & (ctrl_q == OP_ADD || ctrl_q == OP_SUB || ctrl_q == OP_SLT);
               state_d = DONE;
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         carry_q <= 1'b0;
         ctrl_q <= '0;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         zero_q <= 1'b0;
         cout_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         carry_q <= carry_d;
         ctrl_q <= ctrl_d;
         a_q <= a_d;
         b_q <= b_d;
         res_q <= res_d;
         zero_q <= zero_d;
         cout_q <= cout_d;
         ovf_q <= ovf_d;
      end
   end
   assign in_ready = rst_n & (state_q == IDLE);
   assign out_valid = state_q == DONE;
   assign result = res_q;
   assign zero = zero_q;
   assign cout = cout_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_bit_alu.sv
// tb_serial_bit_alu: directed vectors for serial_bit_alu (WIDTH=8), checked
// by a scoreboard queue drained at each result handoff.
module tb_serial_bit_alu;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, out_valid, out_ready, zero, cout, overflow;
   logic [W-1:0] a, b, result;
   logic [3:0] ctrl;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [W-1:0] r;
      logic z, c, v;
   } exp_t;
   exp_t sb[$];
   serial_bit_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .cout(cout), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_output actual=%h expected=none", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.r));
            chk("zero", 32'(zero), 32'(e.z));
            chk("cout", 32'(cout), 32'(e.c));
            chk("overflow", 32'(overflow), 32'(e.v));
         end
      end
   end
   task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      ctrl = c; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      ctrl = 4'($urandom);
   endtask
   task automatic op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] r, input logic z, input logic co, input logic v, input int hold);
      int k = 0;
      exp_t e;
      e.r = r; e.z = z; e.c = co; e.v = v;
      sb.push_back(e);
      issue(c, x, y);
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency", 32'(k), 32'd8);
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         a = 8'h11; b = 8'h22; ctrl = 4'b0010;
         @(posedge clk); #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result", 32'(result), 32'(r));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_handoff_in_ready", 32'(in_ready), 32'd1);
      chk("post_handoff_out_valid", 32'(out_valid), 32'd0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; ctrl = '0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      op(4'b0010, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0);
      op(4'b0110, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0);
      op(4'b0110, 8'h80, 8'h01, 8'h7F, 0, 1, 1, 0);
      op(4'b0111, 8'hFF, 8'h01, 8'h01, 0, 1, 0, 0);
      op(4'b0101, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
      op(4'b0111, 8'h01, 8'hFF, 8'h00, 1, 0, 0, 0);
      op(4'b0101, 8'h01, 8'hFF, 8'h01, 0, 0, 0, 0);
      op(4'b0000, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
      op(4'b0001, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 0);
      op(4'b0011, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0, 0);
      op(4'b0100, 8'hF0, 8'h3C, 8'h00, 1, 0, 0, 0);
      op(4'b0010, 8'h12, 8'h34, 8'h46, 0, 0, 0, 5);
      op(4'b0001, 8'h0F, 8'hF0, 8'hFF, 0, 0, 0, 0);
      issue(4'b0010, 8'hAA, 8'h55);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_rst_result", 32'(result), 32'd0);
      chk("midrun_rst_flags", 32'({zero, cout, overflow}), 32'd0);
      chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      chk("midrun_rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rerelease_in_ready", 32'(in_ready), 32'd1);
      op(4'b0010, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
